// File: rtl/piso_pkg.sv
// Shared helpers for the PISO width down-converter: log2 sizing, width-ratio check and FSM encoding.
package piso_pkg;

  // Single-bit state encoding keeps the FSM to one flop.
  localparam logic StIdle  = 1'b0;
  localparam logic StShift = 1'b1;

  // Ceiling log2; c_log_2(1) == 0.
  function automatic int unsigned c_log_2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // The input word must split into a whole number of output slices.
  function automatic bit widths_ok(input int unsigned in_width, input int unsigned out_width);
    return (out_width != 0) && (in_width >= out_width) && ((in_width % out_width) == 0);
  endfunction

endpackage

// File: rtl/piso_if.sv
// Load and slice handshakes of the PISO; master is the surrounding fabric, slave is the PISO.
interface piso_if #(
  parameter int unsigned DATA_IN_WIDTH  = 64,
  parameter int unsigned DATA_OUT_WIDTH = 16
) ();

  logic                      in_valid;
  logic [DATA_IN_WIDTH-1:0]  data_in;
  logic                      in_ready;
  logic                      out_ready;
  logic [DATA_OUT_WIDTH-1:0] data_out;
  logic                      out_valid;
  logic                      out_last;

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  in_ready,
    input  data_out,
    input  out_valid,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output in_ready,
    output data_out,
    output out_valid,
    output out_last
  );

endinterface

// File: rtl/piso.sv
// Parallel-in serial-out down-converter: one wide word in, NUM_SHIFTS narrow slices out, LSB first.
// Reloads on the final slice transfer so consecutive words stream without a bubble.
module piso
  import piso_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH  = 64,
  parameter int unsigned DATA_OUT_WIDTH = 16
) (
  input logic   clk,
  input logic   rst_n,
  piso_if.slave bus
);

  localparam int unsigned NUM_SHIFTS  = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int unsigned COUNT_WIDTH = c_log_2(NUM_SHIFTS) + 1;

  localparam logic [COUNT_WIDTH-1:0] CountFull = COUNT_WIDTH'(NUM_SHIFTS);
  localparam logic [COUNT_WIDTH-1:0] CountOne  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CountZero = '0;

  if (!widths_ok(DATA_IN_WIDTH, DATA_OUT_WIDTH)) begin : gen_width_err
    $error("piso: DATA_IN_WIDTH (%0d) is not a multiple of DATA_OUT_WIDTH (%0d)",
           DATA_IN_WIDTH, DATA_OUT_WIDTH);
  end

  logic                     state_q, state_d;
  logic [DATA_IN_WIDTH-1:0] shift_q, shift_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;

  logic in_ready;
  logic out_valid;
  logic out_last;
  logic load;
  logic xfer;

  assign load = bus.in_valid && in_ready;
  assign xfer = out_valid && bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      count_q <= CountZero;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StShift;
          shift_d = bus.data_in;
          count_d = CountFull;
        end
      end
      StShift: begin
        if (xfer) begin
          if (count_q > CountOne) begin
            shift_d = shift_q >> DATA_OUT_WIDTH;
            count_d = count_q - CountOne;
          end else if (load) begin
            shift_d = bus.data_in;
            count_d = CountFull;
          end else begin
            // Clearing the word keeps data_out at zero while idle.
            state_d = StIdle;
            shift_d = '0;
            count_d = CountZero;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs; in_ready looks at out_ready so the next word loads on the last slice's edge.
  always_comb begin
    out_valid = (state_q == StShift);
    out_last  = (state_q == StShift) && (count_q == CountOne);
    in_ready  = (state_q == StIdle) || ((count_q == CountOne) && bus.out_ready);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.data_out  = shift_q[DATA_OUT_WIDTH-1:0];

endmodule

// File: tb/tb_piso.sv
// Self-checking bench for piso: 64->16 instance plus a degenerate 16->16 instance, scoreboard-driven.
module tb_piso;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  piso_if #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) bus ();
  piso_if #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) bus1 ();

  piso #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  piso #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // {last, slice} expected from the 64->16 instance, in emission order.
  logic [16:0] exp_q[$];
  logic [15:0] exp1_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] w);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'(i == 3), w[i*16 +: 16]});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.data_in = '0; bus1.out_ready = 1'b1;
    #12;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    n_cmp++; if (bus.data_out !== 16'h0) begin n_err++; $display("FAIL reset_data_out: got %h want 0000", bus.data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_ns1_valid: got %b want 0", bus1.out_valid); end
    tick();
  endtask

  task automatic test_single();
    logic [16:0] e;
    bus.in_valid = 1'b1; bus.data_in = 64'h4444_3333_2222_1111; bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
    push_word(bus.data_in);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d]: got %b want 1", k, bus.out_valid); end
      n_cmp++; if (bus.data_out !== e[15:0]) begin n_err++; $display("FAIL single_data[%0d]: got %h want %h", k, bus.data_out, e[15:0]); end
      n_cmp++; if (bus.out_last !== e[16]) begin n_err++; $display("FAIL single_last[%0d]: got %b want %b", k, bus.out_last, e[16]); end
      n_cmp++; if (bus.in_ready !== e[16]) begin n_err++; $display("FAIL single_in_ready[%0d]: got %b want %b", k, bus.in_ready, e[16]); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", bus.out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] words [2];
    logic [16:0] e;
    logic        load;
    int          sent, got;
    bit          started;
    words[0] = 64'hA004_A003_A002_A001;
    words[1] = 64'hB004_B003_B002_B001;
    sent = 0; got = 0; started = 1'b0;
    bus.in_valid = 1'b1; bus.data_in = words[0]; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      @(negedge clk);
      if (started) begin
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_bubble[%0d]: got %b want 1", got, bus.out_valid); end
      end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        started = 1'b1;
        e = exp_q.pop_front();
        n_cmp++; if (bus.data_out !== e[15:0]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", got, bus.data_out, e[15:0]); end
        n_cmp++; if (bus.out_last !== e[16]) begin n_err++; $display("FAIL b2b_last[%0d]: got %b want %b", got, bus.out_last, e[16]); end
        n_cmp++; if (bus.in_ready !== e[16]) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", got, bus.in_ready, e[16]); end
        got++;
      end
      load = bus.in_valid && bus.in_ready;
      if (load) begin
        push_word(bus.data_in);
        sent++;
      end
      tick();
      if (load) begin
        if (sent < 2) bus.data_in = words[sent];
        else bus.in_valid = 1'b0;
      end
    end
    n_cmp++; if (got != 8) begin n_err++; $display("FAIL b2b_count: got %0d slices want 8", got); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", bus.out_valid); end
    exp_q.delete();
    tick();
  endtask

  task automatic test_backpressure();
    logic [16:0] e;
    bus.in_valid = 1'b1; bus.data_in = 64'h4444_3333_2222_1111; bus.out_ready = 1'b1;
    @(negedge clk);
    push_word(bus.data_in);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if (bus.data_out !== e[15:0]) begin n_err++; $display("FAIL bp_slice1: got %h want %h", bus.data_out, e[15:0]); end
    tick();
    // Stall with a junk word offered; it must be ignored.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.data_in = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = exp_q[0];
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, bus.out_valid); end
      n_cmp++; if (bus.data_out !== e[15:0]) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h want %h", k, bus.data_out, e[15:0]); end
      n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL bp_hold_last[%0d]: got %b want 0", k, bus.out_last); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, bus.in_ready); end
      tick();
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (bus.data_out !== e[15:0]) begin n_err++; $display("FAIL bp_resume_data[%0d]: got %h want %h", k, bus.data_out, e[15:0]); end
      n_cmp++; if (bus.out_last !== e[16]) begin n_err++; $display("FAIL bp_resume_last[%0d]: got %b want %b", k, bus.out_last, e[16]); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b want 0", bus.out_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [16:0] e;
    bus.in_valid = 1'b1; bus.data_in = 64'h4444_3333_2222_1111; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.data_out !== 16'h1111) begin n_err++; $display("FAIL rst_mid_slice1: got %h want 1111", bus.data_out); end
    tick();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.data_out !== 16'h0) begin n_err++; $display("FAIL rst_mid_data: got %h want 0000", bus.data_out); end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_partial: got %b want 0", bus.out_valid); end
    tick();
    bus.in_valid = 1'b1; bus.data_in = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    push_word(bus.data_in);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_new_valid[%0d]: got %b want 1", k, bus.out_valid); end
      n_cmp++; if (bus.data_out !== e[15:0]) begin n_err++; $display("FAIL rst_new_data[%0d]: got %h want %h", k, bus.data_out, e[15:0]); end
      n_cmp++; if (bus.out_last !== e[16]) begin n_err++; $display("FAIL rst_new_last[%0d]: got %b want %b", k, bus.out_last, e[16]); end
      tick();
    end
  endtask

  // Random traffic reassembled by a SIPO model; each rebuilt word must match what was loaded.
  task automatic test_loopback();
    logic [63:0] words_q[$];
    logic [63:0] acc, w;
    logic        load, xfer;
    int          sent, got, nslice;
    sent = 0; got = 0; nslice = 0; acc = '0;
    bus.in_valid = 1'b1; bus.data_in = {$urandom, $urandom};
    bus.out_ready = ($urandom_range(0, 3) != 0);
    for (int cyc = 0; cyc < 5000 && got < 100; cyc++) begin
      @(negedge clk);
      load = bus.in_valid && bus.in_ready;
      xfer = bus.out_valid && bus.out_ready;
      if (xfer) begin
        acc = {bus.data_out, acc[63:16]};
        nslice++;
        n_cmp++; if (bus.out_last !== 1'(nslice == 4)) begin n_err++; $display("FAIL loop_last[%0d]: got %b at slice %0d", got, bus.out_last, nslice); end
        if (nslice == 4) begin
          nslice = 0;
          if (words_q.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL loop_spurious: got word %h want none", acc);
          end else begin
            w = words_q.pop_front();
            n_cmp++; if (acc !== w) begin n_err++; $display("FAIL loop_word[%0d]: got %h want %h", got, acc, w); end
          end
          got++;
        end
      end
      if (load) begin
        words_q.push_back(bus.data_in);
        sent++;
      end
      tick();
      if (load) bus.data_in = {$urandom, $urandom};
      bus.in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    n_cmp++; if (got != 100) begin n_err++; $display("FAIL loop_count: got %0d words want 100", got); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_single_shift();
    logic [15:0] e;
    logic        load, prev_load;
    int          sent, got;
    sent = 0; got = 0; prev_load = 1'b0;
    bus1.in_valid = 1'b1; bus1.data_in = 16'hC000; bus1.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      @(negedge clk);
      if (prev_load) begin
        n_cmp++; if (bus1.out_valid !== 1'b1) begin n_err++; $display("FAIL ns1_latency[%0d]: got %b want 1", got, bus1.out_valid); end
      end
      if (bus1.out_valid === 1'b1 && exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        n_cmp++; if (bus1.data_out !== e) begin n_err++; $display("FAIL ns1_data[%0d]: got %h want %h", got, bus1.data_out, e); end
        n_cmp++; if (bus1.out_last !== 1'b1) begin n_err++; $display("FAIL ns1_last[%0d]: got %b want 1", got, bus1.out_last); end
        got++;
      end
      load = bus1.in_valid && bus1.in_ready;
      if (load) begin
        exp1_q.push_back(bus1.data_in);
        sent++;
      end
      prev_load = load;
      tick();
      if (load) begin
        if (sent < 5) bus1.data_in = 16'hC000 + 16'(sent * 16'h0111);
        else bus1.in_valid = 1'b0;
      end
    end
    n_cmp++; if (got != 5) begin n_err++; $display("FAIL ns1_count: got %0d slices want 5", got); end
    @(negedge clk);
    n_cmp++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL ns1_idle: got %b want 0", bus1.out_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_loopback();
    test_single_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso.md
Name: piso

Overview:
- Parallel-in, serial-out width down-converter; the transmit-side counterpart of the team's SIPO packer.
- Accepts one DATA_IN_WIDTH word per handshake and emits it as NUM_SHIFTS slices of DATA_OUT_WIDTH, LSB slice first. A SIPO on the far end therefore reassembles the original word bit-exact.
- Sits between wide on-chip buffers (PE output / psum words) and narrow DRAM/NoC streams.

Parameters:
- DATA_IN_WIDTH, 64, width of parallel input word.
- DATA_OUT_WIDTH, 16, width of each serial output slice. DATA_IN_WIDTH must be an integer multiple of it.
- NUM_SHIFTS (localparam), DATA_IN_WIDTH/DATA_OUT_WIDTH, slices per word.
- COUNT_WIDTH (localparam), C_LOG_2(NUM_SHIFTS)+1, slice counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in holds a word to load.
- data_in  input  DATA_IN_WIDTH  parallel word.
- in_ready  output  1  block can accept data_in this cycle.
- out_ready  input  1  downstream consumes data_out this cycle.
- data_out  output  DATA_OUT_WIDTH  current slice.
- out_valid  output  1  data_out is valid.
- out_last  output  1  current slice is the final slice of its word.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n. All state regs clear immediately on rst_n low.
- Reset values: out_valid=0, out_last=0, data_out=0, count=0, shift=0, state=IDLE. in_ready=1 once reset is released.
- Load handshake: load when in_valid && in_ready. Output handshake: slice transfer when out_valid && out_ready.
- State machine:
  - IDLE: in_ready=1, out_valid=0. On load, capture data_in into shift, set count=NUM_SHIFTS, go to SHIFT.
  - SHIFT: out_valid=1, data_out=shift[DATA_OUT_WIDTH-1:0], out_last=(count==1).
  - On a slice transfer with count>1: shift right by DATA_OUT_WIDTH (zero fill), count-=1.
  - On a slice transfer with count==1: if a simultaneous load occurs, reload shift and count=NUM_SHIFTS and stay in SHIFT; otherwise go to IDLE.
- in_ready is combinational: (state==IDLE) || (count==1 && out_ready). This gives zero-bubble back-to-back words, so sustained throughput is 1 slice/cycle.
- Latency: word loaded at edge N, first slice valid in the cycle after edge N. Last slice is presented NUM_SHIFTS-1 cycles later, assuming no stalls.
- Stall: out_ready=0 holds data_out, out_valid, out_last and count stable. in_valid is ignored while in_ready=0.
- Degenerate DATA_IN_WIDTH==DATA_OUT_WIDTH (NUM_SHIFTS=1): behaves as a single-entry skid-free register. out_last is always 1 when valid; no shift is performed.
- in_valid=1 in IDLE with out_ready=0: the word still loads, and out_valid rises the next cycle and holds.
- Reset mid-word discards remaining slices; no partial output after rst_n rises.
- A non-multiple width combination is a configuration error: an initial-block $error in simulation.

Decomposition:
- The shared include header (the one providing C_LOG_2) holds the log2 macro. Width-ratio checks go in the same header.
- No typedefs needed. State is a single bit: IDLE and SHIFT localparams.
- No sub-module: counter, shifter and handshake fit in one module (~150 lines). No Delay instance required.

Test Plan:
- Single word, out_ready=1 (64→16): load 0x4444_3333_2222_1111. Expect data_out 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles; out_last only on 0x4444; out_valid low afterwards.
- Back-to-back: in_valid held high with words A then B. Expect 8 consecutive valid slices with no bubble, in_ready pulses high exactly on each out_last cycle, and B's first slice follows A's last.
- Backpressure: deassert out_ready for 3 cycles after slice 2. Expect slice 2 (0x2222) held for 3 cycles, in_ready=0 throughout, then 0x3333 and 0x4444 resume.
- Loopback: connect piso→sipo (16→64) with 100 random words and random out_ready. Expect every reassembled sipo word to equal the piso input word.
- Reset mid-word: assert rst_n low after slice 2. Expect out_valid=0 and data_out=0 immediately. After release, a new word 0xDEAD_BEEF_CAFE_F00D emits F00D, CAFE, BEEF, DEAD.
- NUM_SHIFTS=1 (16→16): stream 5 words. Expect out_last=1 on every slice and 1-cycle latency.
